// File: rtl/skew_delay_array_pkg.sv
// Shared depth arithmetic for the skew/deskew array; feeders and collectors use
// the same functions to align latency with the lanes they face.
package skew_delay_array_pkg;

  // Depth of lane k: grows with k in skew mode, shrinks with k in deskew mode.
  function automatic int unsigned lane_depth(input int unsigned k, input int unsigned lanes,
                                             input int unsigned base, input int unsigned step,
                                             input bit reverse);
    return reverse ? base + (lanes - 1 - k) * step : base + k * step;
  endfunction

  function automatic int unsigned max_depth(input int unsigned lanes, input int unsigned base,
                                            input int unsigned step);
    return base + (lanes - 1) * step;
  endfunction

  function automatic int unsigned total_stages(input int unsigned lanes, input int unsigned base,
                                               input int unsigned step, input bit reverse);
    int unsigned sum;
    sum = 0;
    for (int unsigned k = 0; k < lanes; k++) begin
      sum += lane_depth(k, lanes, base, step, reverse);
    end
    return sum;
  endfunction

endpackage

// File: rtl/skew_delay_array_lane.sv
// Single stall-able delay lane of DEPTH {valid, data} stages; DEPTH=0 is a wire.
module skew_lane #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             stage_busy
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign out_valid        = in_valid & en & ~flush;
    assign out_data         = in_data;
    assign stage_busy       = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Flush clears like reset and wins over en, so a same-cycle input is dropped.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        valid_q <= '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          data_q[i] <= '0;
        end
      end else if (en) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign out_valid  = valid_q[DEPTH-1];
    assign out_data   = data_q[DEPTH-1];
    assign stage_busy = |valid_q;
  end

endmodule

// File: rtl/skew_delay_array.sv
// Multi-lane delay array: lane k delayed by lane_depth(k) en-edges, producing or
// removing the diagonal skew at a systolic array boundary.
module skew_delay_array
  import skew_delay_array_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LANES   = 4,
  parameter int unsigned BASE    = 1,
  parameter int unsigned STEP    = 1,
  parameter int unsigned REVERSE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  if (LANES < 1 || WIDTH < 1) begin : g_param_err
    $error("skew_delay_array: LANES and WIDTH must both be at least 1");
  end

  logic [LANES-1:0] lane_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(
      .WIDTH(WIDTH),
      .DEPTH(lane_depth(k, LANES, BASE, STEP, REVERSE != 0))
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data[k*WIDTH +: WIDTH]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .stage_busy(lane_busy[k])
    );
  end

  assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_delay_array.sv
// Directed bench: skew, deskew and pass-through instances share one stimulus stream;
// a capture scoreboard predicts every lane output and busy after each edge.
module tb_skew_delay_array;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;

  logic [3:0]  sk_valid, dk_valid, ps_valid;
  logic [31:0] sk_data, dk_data, ps_data;
  logic        sk_busy, dk_busy, ps_busy;

  skew_delay_array #(.WIDTH(8), .LANES(4), .BASE(1), .STEP(1), .REVERSE(0)) u_skew (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .out_valid(sk_valid), .out_data(sk_data), .busy(sk_busy)
  );

  skew_delay_array #(.WIDTH(8), .LANES(4), .BASE(1), .STEP(1), .REVERSE(1)) u_deskew (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .out_valid(dk_valid), .out_data(dk_data), .busy(dk_busy)
  );

  skew_delay_array #(.WIDTH(8), .LANES(4), .BASE(0), .STEP(0), .REVERSE(0)) u_pass (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ps_valid), .out_data(ps_data), .busy(ps_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cap;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int unsigned en_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word captured in en-cycle cap is at lane k output while en_cnt == cap + depth.
  task automatic check_lanes(input string tag, input bit rev, input logic [3:0] ov,
                             input logic [31:0] od, input logic bz);
    logic        exp_v;
    logic [7:0]  exp_d;
    int unsigned d;
    for (int k = 0; k < 4; k++) begin
      d     = rev ? 4 - k : 1 + k;
      exp_v = 1'b0;
      exp_d = '0;
      foreach (sb[i]) begin
        if (sb[i].cap + d == en_cnt) begin
          exp_v = 1'b1;
          exp_d = sb[i].data[k*8 +: 8];
        end
      end
      chk($sformatf("%s_valid%0d@%0t", tag, k, $time), 32'(ov[k]), 32'(exp_v));
      if (exp_v) chk($sformatf("%s_data%0d@%0t", tag, k, $time), 32'(od[k*8 +: 8]), 32'(exp_d));
    end
    chk($sformatf("%s_busy@%0t", tag, $time), 32'(bz), 32'(sb.size() != 0));
  endtask

  task automatic cycle(input logic r, input logic f, input logic e, input logic v,
                       input logic [31:0] d);
    @(negedge clk);
    reset    = r;
    flush    = f;
    en       = e;
    in_valid = v;
    in_data  = d;
    #1;
    chk("pass_data", ps_data, d);
    chk("pass_valid", 32'(ps_valid), 32'({4{v & e & ~f}}));
    chk("pass_busy", 32'(ps_busy), 32'(0));
    @(posedge clk);
    if (r || f) begin
      sb.delete();
    end else if (e) begin
      if (v) sb.push_back('{cap: en_cnt, data: d});
      en_cnt++;
    end
    while (sb.size() > 0 && sb[0].cap + 4 < en_cnt) void'(sb.pop_front());
    #1;
    check_lanes("skew", 1'b0, sk_valid, sk_data, sk_busy);
    check_lanes("deskew", 1'b1, dk_valid, dk_data, dk_busy);
    if (r || f) begin
      chk("skew_clr_data", sk_data, 32'h0);
      chk("deskew_clr_data", dk_data, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, $urandom);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;

    // Power-up reset, then reset in the middle of a stream.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h11223344);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h01010101 * (i + 1));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hCCCCCCCC);
    idle(5);

    // Single word-set latency, skew and deskew.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h40302010);
    idle(5);

    // Word held upstream while stalled, then a stall mid-flight with ignored inputs.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40302010);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40302010);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h40302010);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    idle(6);

    // Flush beats en and drops the same-cycle word.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0A0B0C0D);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h1A1B1C1D);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAAAAAA);
    idle(5);

    // Flush while stalled, then reset while stalled.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h55667788);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h99887766);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hBBBBBBBB);
    idle(5);

    // Back-to-back throughput with incrementing data.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)});
    end
    idle(6);

    // Random mix of stalls, bubbles and occasional flushes.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1, $urandom);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
